// File: rtl/axi_tohost_wr_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI write port into the tohost slave.
// Define AXI_TOHOST_ARB_TIMEOUT_EN to add a B-response watchdog that answers SLVERR.
module axi_tohost_wr_arbiter #(
  parameter int NUM_MST        = 2,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                          clk_i,
  input  logic                                          rstn_i,
  input  logic [NUM_MST-1:0]                            m_aw_valid,
  output logic [NUM_MST-1:0]                            m_aw_ready,
  input  logic [NUM_MST*ADDR_W-1:0]                     m_aw_addr,
  input  logic [NUM_MST-1:0]                            m_w_valid,
  output logic [NUM_MST-1:0]                            m_w_ready,
  input  logic [NUM_MST*DATA_W-1:0]                     m_w_data,
  output logic [NUM_MST-1:0]                            m_b_valid,
  input  logic [NUM_MST-1:0]                            m_b_ready,
  output logic [1:0]                                    m_b_resp,
  output logic                                          s_aw_valid,
  input  logic                                          s_aw_ready,
  output logic [ADDR_W-1:0]                             s_aw_addr,
  output logic [((NUM_MST > 1) ? $clog2(NUM_MST) : 1)-1:0] s_aw_id,
  output logic                                          s_w_valid,
  input  logic                                          s_w_ready,
  output logic [DATA_W-1:0]                             s_w_data,
  input  logic                                          s_b_valid,
  output logic                                          s_b_ready,
  input  logic [1:0]                                    s_b_resp
);

  localparam int ID_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
    ST_ERR  = 2'd3,
`endif
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  logic [NUM_MST-1:0] gnt_oh;
  logic               sel_aw_valid, sel_w_valid, sel_b_ready;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               rr_found;
  logic [ID_W-1:0]    rr_pick;
  logic               aw_fin, w_fin;

  // Steer the granted requester's signals onto the slave side.
  always_comb begin
    gnt_oh       = '0;
    sel_aw_valid = 1'b0;
    sel_w_valid  = 1'b0;
    sel_b_ready  = 1'b0;
    sel_addr     = '0;
    sel_data     = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (gnt_q == ID_W'(i)) begin
        gnt_oh[i]    = 1'b1;
        sel_aw_valid = m_aw_valid[i];
        sel_w_valid  = m_w_valid[i];
        sel_b_ready  = m_b_ready[i];
        sel_addr     = m_aw_addr[i*ADDR_W +: ADDR_W];
        sel_data     = m_w_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // First AW requester found walking ptr+1, ptr+2, ... with wrap-around.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = ptr_q;
    for (int k = 1; k <= NUM_MST; k++) begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (!rr_found && m_aw_valid[i] && (i == (int'(ptr_q) + k) % NUM_MST)) begin
          rr_found = 1'b1;
          rr_pick  = ID_W'(i);
        end
      end
    end
  end

  assign s_aw_addr = sel_addr;
  assign s_w_data  = sel_data;
  assign s_aw_id   = gnt_q;

  // NOTE: every output and next-state variable gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    s_aw_valid = 1'b0;
    s_w_valid  = 1'b0;
    s_b_ready  = 1'b0;
    m_aw_ready = '0;
    m_w_ready  = '0;
    m_b_valid  = '0;
    m_b_resp   = 2'b00;
    aw_fin     = 1'b0;
    w_fin      = 1'b0;
    case (state_q)
      ST_IDLE: begin
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
        s_b_ready = 1'b1;  // drain a B that arrives after its transaction timed out
`endif
        if (rr_found) begin
          gnt_d   = rr_pick;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        s_aw_valid = sel_aw_valid & ~aw_done_q;
        s_w_valid  = sel_w_valid & ~w_done_q;
        m_aw_ready = gnt_oh & {NUM_MST{s_aw_ready & ~aw_done_q}};
        m_w_ready  = gnt_oh & {NUM_MST{s_w_ready & ~w_done_q}};
        aw_fin     = aw_done_q | (s_aw_valid & s_aw_ready);
        w_fin      = w_done_q | (s_w_valid & s_w_ready);
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_RESP;
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      ST_RESP: begin
        m_b_valid = gnt_oh & {NUM_MST{s_b_valid}};
        m_b_resp  = s_b_resp;
        s_b_ready = sel_b_ready;
        if (s_b_valid && sel_b_ready) begin
          ptr_d   = gnt_q;
          state_d = ST_IDLE;
        end
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
        else if (!s_b_valid) begin
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = ST_ERR;
          else                                      cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
      ST_ERR: begin
        m_b_valid = gnt_oh;
        m_b_resp  = 2'b10;
        if (sel_b_ready) begin
          ptr_d   = gnt_q;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ptr_q     <= ID_W'(NUM_MST - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_tohost_wr_arbiter.sv
// Bench for axi_tohost_wr_arbiter: transaction-level model checked every cycle plus directed scenarios.
module tb_axi_tohost_wr_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 16;
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rstn_i;
  logic [N-1:0]    m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic [N*AW-1:0] m_aw_addr;
  logic [N*DW-1:0] m_w_data;
  logic [1:0]      m_b_resp;
  logic            s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic [AW-1:0]   s_aw_addr;
  logic [0:0]      s_aw_id;
  logic [DW-1:0]   s_w_data;
  logic [1:0]      s_b_resp;

  axi_tohost_wr_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, which phase, which halves have been accepted.
  typedef enum {P_IDLE, P_XFER, P_RESP, P_ERR} phase_t;
  phase_t ph    = P_IDLE;
  int     own   = 0;
  int     ptr   = N - 1;
  int     tcnt  = 0;
  bit     aw_got = 1'b0;
  bit     w_got  = 1'b0;

  always @(negedge clk_i) begin
    logic         e_aw, e_w, e_br;
    logic [N-1:0] one, e_awr, e_wr, e_bv;
    logic [1:0]   e_resp;
    if (!rstn_i) begin
      check("reset_outputs", {s_aw_valid, s_w_valid, s_b_ready, m_aw_ready, m_w_ready,
                              m_b_valid, m_b_resp, s_aw_id}, 64'd0);
      ph = P_IDLE; own = 0; ptr = N - 1; tcnt = 0; aw_got = 1'b0; w_got = 1'b0;
    end else begin
      one    = {{(N-1){1'b0}}, 1'b1} << own;
      e_aw   = (ph == P_XFER) && m_aw_valid[own] && !aw_got;
      e_w    = (ph == P_XFER) && m_w_valid[own] && !w_got;
      e_awr  = (ph == P_XFER && !aw_got && s_aw_ready) ? one : '0;
      e_wr   = (ph == P_XFER && !w_got && s_w_ready) ? one : '0;
      e_bv   = ((ph == P_RESP && s_b_valid) || ph == P_ERR) ? one : '0;
      e_resp = (ph == P_RESP) ? s_b_resp : (ph == P_ERR) ? 2'b10 : 2'b00;
      e_br   = (ph == P_RESP) ? m_b_ready[own] : (ph == P_IDLE && TO_EN);
      check("s_aw_valid", s_aw_valid, e_aw);
      check("s_w_valid", s_w_valid, e_w);
      check("m_aw_ready", m_aw_ready, e_awr);
      check("m_w_ready", m_w_ready, e_wr);
      check("m_b_valid", m_b_valid, e_bv);
      check("m_b_resp", m_b_resp, e_resp);
      check("s_b_ready", s_b_ready, e_br);
      check("s_aw_id", s_aw_id, own);
      if (e_aw) check("s_aw_addr", s_aw_addr, m_aw_addr[own*AW +: AW]);
      if (e_w)  check("s_w_data", s_w_data, m_w_data[own*DW +: DW]);
      case (ph)
        P_IDLE: if (|m_aw_valid) begin
          for (int k = 1; k <= N; k++) begin
            if (m_aw_valid[(ptr + k) % N]) begin
              own = (ptr + k) % N;
              break;
            end
          end
          ph = P_XFER;
        end
        P_XFER: begin
          aw_got = aw_got | (e_aw & s_aw_ready);
          w_got  = w_got | (e_w & s_w_ready);
          if (aw_got && w_got) begin
            aw_got = 1'b0; w_got = 1'b0; tcnt = 0; ph = P_RESP;
          end
        end
        P_RESP: begin
          if (s_b_valid && m_b_ready[own]) begin
            ptr = own; ph = P_IDLE;
          end else if (TO_EN && !s_b_valid) begin
            tcnt++;
            if (tcnt == TO) ph = P_ERR;
          end
        end
        P_ERR: if (m_b_ready[own]) begin
          ptr = own; ph = P_IDLE;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // Master and slave responders: drop valid after a handshake, answer B once AW and W arrived.
  bit b_en      = 1'b1;
  int aw_pend   = 0;
  int w_pend    = 0;
  int aw_pulses = 0;
  int w_pulses  = 0;
  int done_q[$];

  always begin
    logic [N-1:0] awf, wf;
    bit           bt;
    @(negedge clk_i);
    awf = m_aw_valid & m_aw_ready;
    wf  = m_w_valid & m_w_ready;
    bt  = s_b_valid & s_b_ready;
    if (s_aw_valid && s_aw_ready) begin aw_pend++; aw_pulses++; end
    if (s_w_valid && s_w_ready)   begin w_pend++;  w_pulses++;  end
    for (int i = 0; i < N; i++) if (m_b_valid[i] && m_b_ready[i]) done_q.push_back(i);
    @(posedge clk_i);
    #1;
    m_aw_valid = m_aw_valid & ~awf;
    m_w_valid  = m_w_valid & ~wf;
    if (bt) begin
      s_b_valid = 1'b0;
      aw_pend--;
      w_pend--;
    end
    if (!s_b_valid && b_en && rstn_i && aw_pend > 0 && w_pend > 0) s_b_valid = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic req(input int i, input logic [63:0] a, input logic [63:0] d, input bit with_w);
    m_aw_addr[i*AW +: AW] = a;
    m_w_data[i*DW +: DW]  = d;
    m_aw_valid[i]         = 1'b1;
    if (with_w) m_w_valid[i] = 1'b1;
  endtask

  task automatic wait_done(input string name, input int n, input int budget);
    int c = 0;
    while (done_q.size() < n && c < budget) begin
      step(1);
      c++;
    end
    check(name, done_q.size(), n);
  endtask

  task automatic do_reset();
    rstn_i     = 1'b0;
    m_aw_valid = '0;
    m_w_valid  = '0;
    s_b_valid  = 1'b0;
    aw_pend    = 0;
    w_pend     = 0;
    step(2);
    rstn_i = 1'b1;
    step(1);
  endtask

  initial begin
    int p_aw, p_w;
    rstn_i     = 1'b0;
    m_aw_valid = '0;
    m_w_valid  = '0;
    m_aw_addr  = '0;
    m_w_data   = '0;
    m_b_ready  = '1;
    s_aw_ready = 1'b1;
    s_w_ready  = 1'b1;
    s_b_valid  = 1'b0;
    s_b_resp   = 2'b00;
    step(2);
    check("reset_all_zero", {s_aw_valid, s_w_valid, s_b_ready, m_aw_ready, m_w_ready,
                             m_b_valid, m_b_resp, s_aw_id}, 64'd0);
    rstn_i = 1'b1;
    step(1);

    // T1: single write from requester 0
    req(0, 64'h8000_1000, 64'h1, 1'b1);
    step(1);
    check("t1_aw_valid", s_aw_valid, 1'b1);
    check("t1_aw_addr", s_aw_addr, 64'h8000_1000);
    check("t1_aw_id", s_aw_id, 0);
    check("t1_w_data", s_w_data, 64'h1);
    step(1);
    check("t1_b_valid", m_b_valid, 2'b01);
    check("t1_b_resp", m_b_resp, 2'b00);
    step(1);
    check("t1_done", done_q.size(), 1);
    check("t1_done_id", done_q[0], 0);

    // T2: both request after reset -> 0 then 1, then 0 again; B resp forwarded unchanged
    do_reset();
    done_q.delete();
    s_b_resp = 2'b01;
    req(0, 64'h100, 64'hA0, 1'b1);
    req(1, 64'h200, 64'hB1, 1'b1);
    wait_done("t2_first_pair", 2, 40);
    check("t2_order0", done_q[0], 0);
    check("t2_order1", done_q[1], 1);
    done_q.delete();
    req(0, 64'h300, 64'hA2, 1'b1);
    req(1, 64'h400, 64'hB3, 1'b1);
    wait_done("t2_second_pair", 2, 40);
    check("t2_again_first", done_q[0], 0);
    s_b_resp = 2'b00;

    // T3: W ahead of AW is not a request; exactly one pulse each
    done_q.delete();
    m_w_data[0 +: DW] = 64'hC0FFEE;
    m_w_valid[0]      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t3_w_alone_idle", {s_w_valid, m_w_ready}, 3'b000);
      step(1);
    end
    p_aw = aw_pulses;
    p_w  = w_pulses;
    req(0, 64'h8000_2000, 64'hC0FFEE, 1'b0);
    wait_done("t3_early_w", 1, 20);
    check("t3_aw_pulses", aw_pulses - p_aw, 1);
    check("t3_w_pulses", w_pulses - p_w, 1);
    step(1);
    done_q.delete();
    p_aw = aw_pulses;
    p_w  = w_pulses;
    req(0, 64'h8000_3000, 64'h55, 1'b1);
    step(1);
    check("t3_same_cycle_hs", {s_aw_valid, s_w_valid}, 2'b11);
    step(1);
    check("t3_resp_next", m_b_valid, 2'b01);
    step(1);
    check("t3_aw_pulses2", aw_pulses - p_aw, 1);
    check("t3_w_pulses2", w_pulses - p_w, 1);

    // T4: slave AW stall, requester 1 waits for requester 0's B
    done_q.delete();
    s_aw_ready = 1'b0;
    req(0, 64'h8000_4000, 64'h44, 1'b1);
    step(1);
    req(1, 64'h8000_5000, 64'h45, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t4_aw_ready_low", m_aw_ready, 2'b00);
      check("t4_addr_stable", s_aw_addr, 64'h8000_4000);
      step(1);
    end
    s_aw_ready = 1'b1;
    wait_done("t4_both", 2, 40);
    check("t4_order0", done_q[0], 0);
    check("t4_order1", done_q[1], 1);

    // T5: reset while in RESP
    b_en = 1'b0;
    req(0, 64'h8000_6000, 64'h66, 1'b1);
    step(2);
    check("t5_in_resp", s_b_ready, 1'b1);
    rstn_i = 1'b0;
    #1;
    check("t5_async_zero", {s_aw_valid, s_w_valid, s_b_ready, m_aw_ready, m_w_ready,
                            m_b_valid, m_b_resp, s_aw_id}, 64'd0);
    m_aw_valid = '0;
    m_w_valid  = '0;
    s_b_valid  = 1'b0;
    aw_pend    = 0;
    w_pend     = 0;
    b_en       = 1'b1;
    step(2);
    rstn_i = 1'b1;
    done_q.delete();
    req(0, 64'h700, 64'h70, 1'b1);
    req(1, 64'h800, 64'h80, 1'b1);
    step(1);
    check("t5_first_gnt", {s_aw_valid, s_aw_id}, 2'b10);
    wait_done("t5_pair", 2, 40);
    check("t5_order0", done_q[0], 0);

    // T6: slave never answers B
    done_q.delete();
    b_en = 1'b0;
    req(0, 64'h8000_7000, 64'h77, 1'b1);
    step(2);
`ifdef AXI_TOHOST_ARB_TIMEOUT_EN
    step(TO - 1);
    check("t6_still_resp", {s_b_ready, m_b_valid}, 3'b100);
    step(1);
    check("t6_err_valid", m_b_valid, 2'b01);
    check("t6_err_resp", m_b_resp, 2'b10);
    step(1);
    check("t6_idle_drain", s_b_ready, 1'b1);
    b_en = 1'b1;
    step(4);
    check("t6_one_completion", done_q.size(), 1);
    check("t6_late_b_dropped", aw_pend, 0);
`else
    step(1000);
    check("t6_still_resp", {s_b_ready, m_b_valid}, 3'b100);
    b_en = 1'b1;
    wait_done("t6_release", 1, 10);
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
